operand_serializer: RTL and testbench
=====================================

// Module: operand_serializer
// PURPOSE
//  Upstream feeder for the bit-serial summator. Accepts operand pairs (a, b) in
//  parallel over a valid/ready handshake and streams them LSB-first, one bit per clk.
//  Each frame ends with one zero flush bit so the adder's final carry lands in sum MSB.
//  A one-entry hold register lets the next pair queue during a frame.
//  Frames then run back-to-back with no idle cycle between them.
// PARAMETERS
//  reglength  3  operand width in bits (>=1); frame length = reglength+1 cycles
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          operand pair offered
//  in_ready   out  1          pair accepted on posedge when in_valid && in_ready
//  in_a       in   reglength  operand A
//  in_b       in   reglength  operand B
//  bit_valid  out  1          bit_a/bit_b carry a frame bit this cycle
//  bit_a      out  1          current bit of A (0 on flush)
//  bit_b      out  1          current bit of B (0 on flush)
//  bit_first  out  1          frame bit 0; downstream clears carry
//  bit_last   out  1          flush bit (index reglength); downstream captures carry as MSB
//  busy       out  1          frame in progress or pair held
// BEHAVIOUR
//  - Regs: shift regs SA/SB [reglength], counter cnt (0..reglength), hold HA/HB + hold_v, state.
//  - States: IDLE, SHIFT. Outputs decoded from regs only; no in_* -> out combinational path
//    except in_ready = !hold_v.
//  - bit_valid = (state==SHIFT); bit_a = SA[0]; bit_b = SB[0]; bit_first = valid && cnt==0;
//    bit_last = valid && cnt==reglength; busy = (state==SHIFT) || hold_v.
//  - SA/SB shift right logically each SHIFT cycle, zero fill.
//    SA[0]/SB[0] are therefore 0 on the flush cycle.
//  - IDLE: hold_v is always 0. On accept: SA<=in_a, SB<=in_b, cnt<=0, ->SHIFT.
//    Latency: accept at edge N, bit 0 valid in cycle after N.
//  - SHIFT, cnt<reglength: shift, cnt++. Accept (only if !hold_v) loads HA/HB, hold_v<=1.
//  - SHIFT, cnt==reglength (flush cycle):
//      hold_v=1: S<=H, cnt<=0, hold_v<=0, stay SHIFT. in_ready=0 this cycle.
//      hold_v=0, accept: S<=in_*, cnt<=0, stay SHIFT (bypass, no gap).
//      hold_v=0, no accept: ->IDLE, cnt<=0.
//  - Held pair is never overwritten. in_a/in_b are sampled only on the accept edge.
//  - reglength=1: frame = 2 cycles; bit_first on bit 0, bit_last on flush. Never both.
//  - Reset (any state, mid-frame included) on the next edge:
//      state=IDLE, SA=SB=HA=HB=0, cnt=0, hold_v=0.
//      Outputs: bit_valid=bit_a=bit_b=bit_first=bit_last=busy=0, in_ready=1.
//      Partial frame is abandoned and the held pair is dropped.
//      in_valid during the reset cycle is ignored.
// TESTING
//  1 Single pair, reglength=3: a=3'b101, b=3'b011, one accept.
//    -> 4 valid cycles: a=1,0,1,0; b=1,1,0,0; bit_first cycle 1, bit_last cycle 4, then IDLE.
//  2 Three pairs offered continuously: (1,1), (7,7), (2,5).
//    -> ready pattern 1,1,0..; frames contiguous (12 valid cycles, no gap), order preserved.
//  3 Bypass: second pair first presented on flush cycle, hold empty.
//    -> accepted that edge; bit_first on the very next cycle.
//  4 Backpressure: hold full, in_valid held with a=6, b=1.
//    -> in_ready=0 until hold drains; pair emitted exactly once, unchanged.
//  5 rst asserted at cnt=1 with hold_v=1.
//    -> next cycle all outputs 0, in_ready=1; held pair never emitted.
//  6 reglength=1: pairs (1,1),(0,1) back-to-back.
//    -> a=1,0,0,0; b=1,0,1,0; first/last alternate every cycle.

Source files
------------

// File: rtl/operand_serializer.sv
// Serializes (a, b) operand pairs LSB-first for the bit-serial summator, with a
// trailing zero flush bit per frame and a one-entry hold register for back-to-back frames.
module operand_serializer #(
  parameter int unsigned reglength = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [reglength-1:0] in_a,
  input  logic [reglength-1:0] in_b,
  output logic                 bit_valid,
  output logic                 bit_a,
  output logic                 bit_b,
  output logic                 bit_first,
  output logic                 bit_last,
  output logic                 busy
);

  localparam int unsigned cnt_w = (reglength < 1) ? 1 : $clog2(reglength + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(reglength);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state;
  logic [reglength-1:0] sa;
  logic [reglength-1:0] sb;
  logic [reglength-1:0] ha;
  logic [reglength-1:0] hb;
  logic                 hold_v;
  logic [cnt_w-1:0]     cnt;
  logic                 accept;

  assign accept = in_valid && in_ready;

  // All outputs decode registered state only; the sole input-facing output is in_ready.
  assign in_ready  = !hold_v;
  assign bit_valid = (state == SHIFT);
  assign bit_a     = sa[0];
  assign bit_b     = sb[0];
  assign bit_first = bit_valid && (cnt == '0);
  assign bit_last  = bit_valid && (cnt == cnt_last);
  assign busy      = bit_valid || hold_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      ha     <= '0;
      hb     <= '0;
      hold_v <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        sa    <= in_a;
        sb    <= in_b;
        cnt   <= '0;
        state <= SHIFT;
      end
    end else if (cnt != cnt_last) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      cnt <= cnt + cnt_w'(1);
      if (accept) begin
        ha     <= in_a;
        hb     <= in_b;
        hold_v <= 1'b1;
      end
    end else begin
      // Flush cycle: the held pair wins, else a fresh offer bypasses the hold, else go idle.
      cnt <= '0;
      if (hold_v) begin
        sa     <= ha;
        sb     <= hb;
        hold_v <= 1'b0;
      end else if (accept) begin
        sa <= in_a;
        sb <= in_b;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_operand_serializer.sv
// Scoreboard bench for operand_serializer: accepted pairs expand into expected frame bits,
// a negedge monitor pops and compares; two instances cover reglength=3 and reglength=1.
module tb_operand_serializer;

  typedef struct {
    bit a;
    bit b;
    int idx;
  } exp_t;

  logic clk;
  int   checks  = 0;
  int   failures = 0;
  int   n_done  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int unsigned L = (g == 0) ? 3 : 1;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [L-1:0] in_a;
    logic [L-1:0] in_b;
    logic         bit_valid;
    logic         bit_a;
    logic         bit_b;
    logic         bit_first;
    logic         bit_last;
    logic         busy;
    exp_t         q[$];
    bit           armed = 1'b0;

    operand_serializer #(.reglength(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .bit_valid (bit_valid),
      .bit_a     (bit_a),
      .bit_b     (bit_b),
      .bit_first (bit_first),
      .bit_last  (bit_last),
      .busy      (busy)
    );

    task automatic tick();
      @(negedge clk);
      #1;
    endtask

    // Offer a pair until taken; an accepted pair becomes L+1 expected bits (operand bits then a 0).
    task automatic send(input int a, input int b);
      int   waited = 0;
      int   am = a & ((1 << L) - 1);
      int   bm = b & ((1 << L) - 1);
      exp_t e;
      in_valid = 1'b1;
      in_a = L'(am);
      in_b = L'(bm);
      while (!in_ready && waited < 100) begin
        tick();
        waited++;
      end
      if (!in_ready) begin
        checks++;
        failures++;
        $display("FAIL inst%0d send_timeout in_ready=%b required=1", g, in_ready);
        in_valid = 1'b0;
        return;
      end
      for (int i = 0; i <= int'(L); i++) begin
        e.a = ((am >> i) & 1) != 0;
        e.b = ((bm >> i) & 1) != 0;
        e.idx = i;
        q.push_back(e);
      end
      tick();
      in_valid = 1'b0;
      in_a = L'($urandom);
      in_b = L'($urandom);
    endtask

    task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
        in_a = L'($urandom);
        in_b = L'($urandom);
        tick();
      end
    endtask

    // Reset drops everything in flight; an offer during the reset cycle must be ignored.
    task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      in_a = L'($urandom);
      in_b = L'($urandom);
      q.delete();
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
    endtask

    initial begin
      int r;
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      @(posedge clk);
      #1;
      armed = 1'b1;
      tick();
      rst = 1'b0;
      if (L == 3) begin
        send(5, 3); idle(6);
        send(1, 1); send(7, 7); send(2, 5); idle(14);
        send(4, 2); idle(3); send(3, 6); idle(6);
        send(1, 2); send(3, 4); send(6, 1); idle(14);
        send(1, 2); send(3, 4); do_reset(); idle(8);
      end else begin
        send(1, 1); send(0, 1); idle(4);
      end
      for (int k = 0; k < 300; k++) begin
        r = int'($urandom_range(0, 19));
        if (r < 12) send(int'($urandom), int'($urandom));
        else if (r < 19) idle(int'($urandom_range(1, 5)));
        else do_reset();
      end
      idle(2 * int'(L) + 6);
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL inst%0d drain leftover_bits=%0d required=0", g, q.size());
      end
      n_done++;
    end

    // Monitor: the expected output is the head of the bit queue; a frame start still queued
    // behind the current bit means a pair is sitting in the hold register.
    always @(negedge clk) begin
      logic [6:0] act;
      logic [6:0] expv;
      exp_t       e;
      bit         held;
      if (armed) begin
        act = {bit_valid, bit_a, bit_b, bit_first, bit_last, busy, in_ready};
        expv = '0;
        if (q.size() > 0) begin
          e = q.pop_front();
          expv[6] = 1'b1;
          expv[5] = e.a;
          expv[4] = e.b;
          expv[3] = (e.idx == 0);
          expv[2] = (e.idx == int'(L));
        end
        held = 1'b0;
        foreach (q[i]) if (q[i].idx == 0) held = 1'b1;
        expv[1] = expv[6] || held;
        expv[0] = !held;
        checks++;
        if (act !== expv) begin
          failures++;
          $display("FAIL inst%0d outputs(valid,a,b,first,last,busy,ready) actual=%b required=%b t=%0t",
                   g, act, expv, $time);
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < 40000 && n_done < 2; c++) @(negedge clk);
    #2;
    if (n_done < 2) begin
      checks++;
      failures++;
      $display("FAIL run_timeout done=%0d required=2", n_done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
